// File: rtl/tinker_pkg.sv
// Shared definitions for the Tinker sequencer: opcodes, FSM states, latency classes.
// The opcode table is the single source for both the sequencer and the instruction decoder.
package tinker_pkg;

  localparam logic [4:0] OP_AND    = 5'h00;
  localparam logic [4:0] OP_OR     = 5'h01;
  localparam logic [4:0] OP_XOR    = 5'h02;
  localparam logic [4:0] OP_NOT    = 5'h03;
  localparam logic [4:0] OP_SHFTR  = 5'h04;
  localparam logic [4:0] OP_SHFTRI = 5'h05;
  localparam logic [4:0] OP_SHFTL  = 5'h06;
  localparam logic [4:0] OP_SHFTLI = 5'h07;
  localparam logic [4:0] OP_PRIV   = 5'h0F;
  localparam logic [4:0] OP_MOV_RR = 5'h11;
  localparam logic [4:0] OP_MOV_RL = 5'h12;
  localparam logic [4:0] OP_ADDF   = 5'h14;
  localparam logic [4:0] OP_SUBF   = 5'h15;
  localparam logic [4:0] OP_MULF   = 5'h16;
  localparam logic [4:0] OP_DIVF   = 5'h17;
  localparam logic [4:0] OP_ADD    = 5'h18;
  localparam logic [4:0] OP_ADDI   = 5'h19;
  localparam logic [4:0] OP_SUB    = 5'h1A;
  localparam logic [4:0] OP_SUBI   = 5'h1B;
  localparam logic [4:0] OP_MUL    = 5'h1C;
  localparam logic [4:0] OP_DIV    = 5'h1D;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } seq_state_t;

  typedef enum logic [2:0] {
    CLS_1    = 3'd0,
    CLS_MUL  = 3'd1,
    CLS_DIV  = 3'd2,
    CLS_FP   = 3'd3,
    CLS_HALT = 3'd4,
    CLS_ILL  = 3'd5
  } op_class_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tinker_op_class.sv
// Combinational opcode classifier: maps opcode plus literal field to an execute-latency class.
// Anything not listed here is illegal, so the decoder and sequencer agree on the legal set.
module tinker_op_class
  import tinker_pkg::*;
(
  input  logic [4:0]  opcode,
  input  logic [11:0] literal,
  output op_class_t   op_class
);

  // Opcode lookup; priv only halts cleanly with a zero literal
  always_comb begin
    op_class = CLS_ILL;
    case (opcode)
      OP_AND, OP_OR, OP_XOR, OP_NOT,
      OP_SHFTR, OP_SHFTRI, OP_SHFTL, OP_SHFTLI,
      OP_MOV_RR, OP_MOV_RL,
      OP_ADD, OP_ADDI, OP_SUB, OP_SUBI:  op_class = CLS_1;
      OP_MUL:                            op_class = CLS_MUL;
      OP_DIV:                            op_class = CLS_DIV;
      OP_ADDF, OP_SUBF, OP_MULF, OP_DIVF: op_class = CLS_FP;
      OP_PRIV: begin
        if (literal == 12'h000) begin
          op_class = CLS_HALT;
        end else begin
          op_class = CLS_ILL;
        end
      end
      default:                           op_class = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/tinker_sequencer.sv
// Multi-cycle sequencer for the clockless Tinker datapath: fetch, decode, timed execute,
// single-cycle write strobe and PC advance. All outputs come straight from flops.
module tinker_sequencer
  import tinker_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h2000,
  parameter int          MUL_LAT  = 3,
  parameter int          DIV_LAT  = 8,
  parameter int          FP_LAT   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        rf_we,
  output logic [63:0] pc,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] retired
);

  localparam int MAX_LAT = max_int(max_int(MUL_LAT, DIV_LAT), max_int(FP_LAT, 1));
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  localparam logic [CNT_W-1:0] LOAD_1   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] LOAD_MUL = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] LOAD_DIV = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] LOAD_FP  = CNT_W'(FP_LAT - 1);

  seq_state_t       state_r;
  seq_state_t       state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic [31:0]      instr_r;
  logic [63:0]      pc_r;
  logic [31:0]      retired_r;
  logic             illegal_r;
  logic             imem_req_r;
  logic             rf_we_r;
  logic             halted_r;
  op_class_t        cls_s;

  tinker_op_class u_op_class (
    .opcode   (instr_r[31:27]),
    .literal  (instr_r[11:0]),
    .op_class (cls_s)
  );

  // Next-state and execute-counter logic
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (run) begin
          state_next_s = FETCH;
        end else begin
          state_next_s = IDLE;
        end
      end
      FETCH: begin
        if (imem_ack) begin
          state_next_s = DECODE;
        end else begin
          state_next_s = FETCH;
        end
      end
      DECODE: begin
        case (cls_s)
          CLS_1:   begin cnt_next_s = LOAD_1;   state_next_s = EXEC; end
          CLS_MUL: begin cnt_next_s = LOAD_MUL; state_next_s = EXEC; end
          CLS_DIV: begin cnt_next_s = LOAD_DIV; state_next_s = EXEC; end
          CLS_FP:  begin cnt_next_s = LOAD_FP;  state_next_s = EXEC; end
          CLS_HALT: state_next_s = HALT;
          CLS_ILL:  state_next_s = HALT;
          default:  state_next_s = HALT;
        endcase
      end
      EXEC: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_next_s = WB;
        end else begin
          cnt_next_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      WB: begin
        if (run) begin
          state_next_s = FETCH;
        end else begin
          state_next_s = IDLE;
        end
      end
      HALT:    state_next_s = HALT;
      default: state_next_s = IDLE;
    endcase
  end

  // State, counter and strobe registers; strobes mirror the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      imem_req_r <= 1'b0;
      rf_we_r    <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      cnt_r      <= cnt_next_s;
      imem_req_r <= (state_next_s == FETCH);
      rf_we_r    <= (state_next_s == WB);
      halted_r   <= (state_next_s == HALT);
    end
  end

  // Architectural state: instruction latch, PC, retire count, illegal flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_r   <= 32'h0000_0000;
      pc_r      <= RESET_PC;
      retired_r <= 32'd0;
      illegal_r <= 1'b0;
    end else begin
      if (state_r == FETCH && imem_ack) begin
        instr_r <= imem_rdata;
      end
      if (state_r == WB) begin
        pc_r      <= pc_r + 64'd4;
        retired_r <= retired_r + 32'd1;
      end
      if (state_r == DECODE && cls_s == CLS_ILL) begin
        illegal_r <= 1'b1;
      end
    end
  end

  assign imem_req  = imem_req_r;
  assign imem_addr = pc_r;
  assign instr     = instr_r;
  assign rf_we     = rf_we_r;
  assign pc        = pc_r;
  assign halted    = halted_r;
  assign illegal   = illegal_r;
  assign retired   = retired_r;

endmodule

// File: tb/tb_tinker_sequencer.sv
// Directed bench for tinker_sequencer: small instruction memory with programmable ack delay,
// hand-computed cycle positions for strobes, PC and status flags.
module tb_tinker_sequencer;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        rf_we;
  logic [63:0] pc;
  logic        halted;
  logic        illegal;
  logic [31:0] retired;

  logic [31:0] prog [16];
  logic [63:0] off_s;
  int          mem_delay;
  int          req_cyc;
  int          rf_cnt;
  int          req_cnt;
  int          vec_cnt;
  int          err_cnt;

  tinker_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .rf_we      (rf_we),
    .pc         (pc),
    .halted     (halted),
    .illegal    (illegal),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: ack after mem_delay wait cycles of an active request
  assign off_s      = imem_addr - 64'h2000;
  assign imem_rdata = prog[off_s[5:2]];
  assign imem_ack   = imem_req && (req_cyc == mem_delay);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) req_cyc <= 0;
    else if (imem_req && !imem_ack) req_cyc <= req_cyc + 1;
    else req_cyc <= 0;
  end

  initial begin
    rf_cnt  = 0;
    req_cnt = 0;
  end

  always @(posedge clk) begin
    if (rf_we) rf_cnt <= rf_cnt + 1;
    if (imem_req) req_cnt <= req_cnt + 1;
  end

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    run   = 1'b0;
    for (int i = 0; i < 16; i++) prog[i] = 32'h7800_0000;
    @(negedge clk);
  endtask

  task automatic start_run();
    rst_n = 1'b1;
    run   = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  int rf0;
  int rq0;
  int req_at;
  int rf_at;

  initial begin
    vec_cnt   = 0;
    err_cnt   = 0;
    mem_delay = 0;
    rst_n     = 1'b0;
    run       = 1'b0;
    for (int i = 0; i < 16; i++) prog[i] = 32'h7800_0000;
    step(2);
    check_vec("rst_pc", pc, 64'h2000);
    check_vec("rst_instr", {32'd0, instr}, 64'd0);
    check_vec("rst_rf_we", {63'd0, rf_we}, 64'd0);
    check_vec("rst_req", {63'd0, imem_req}, 64'd0);
    check_vec("rst_halted", {63'd0, halted}, 64'd0);
    check_vec("rst_illegal", {63'd0, illegal}, 64'd0);
    check_vec("rst_retired", {32'd0, retired}, 64'd0);

    // add, zero-wait memory, followed by a clean priv halt
    prog[0] = 32'hC000_0000;
    prog[1] = 32'h7800_0000;
    start_run();
    step(1);
    check_vec("add_c1_req", {63'd0, imem_req}, 64'd1);
    check_vec("add_c1_addr", imem_addr, 64'h2000);
    step(1);
    check_vec("add_c2_rf_we", {63'd0, rf_we}, 64'd0);
    check_vec("add_c2_instr", {32'd0, instr}, 64'hC000_0000);
    step(1);
    check_vec("add_c3_rf_we", {63'd0, rf_we}, 64'd0);
    step(1);
    check_vec("add_c4_rf_we", {63'd0, rf_we}, 64'd1);
    step(1);
    check_vec("add_pc", pc, 64'h2004);
    check_vec("add_retired", {32'd0, retired}, 64'd1);
    check_vec("b2b_req", {63'd0, imem_req}, 64'd1);
    check_vec("b2b_addr", imem_addr, 64'h2004);
    step(3);
    check_vec("priv_halted", {63'd0, halted}, 64'd1);
    check_vec("priv_illegal", {63'd0, illegal}, 64'd0);
    rf0 = rf_cnt;
    rq0 = req_cnt;
    step(20);
    check_vec("priv_no_rf_we", 64'(rf_cnt - rf0), 64'd0);
    check_vec("priv_no_req", 64'(req_cnt - rq0), 64'd0);
    check_vec("priv_pc_held", pc, 64'h2004);

    // div: rf_we in the 11th cycle counting the first request cycle as 1
    do_reset();
    prog[0] = 32'hE800_0000;
    start_run();
    req_at = 0;
    rf_at  = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (imem_req && req_at == 0) req_at = n;
      if (rf_we) begin
        rf_at = n;
        break;
      end
    end
    check_vec("div_req_cycle", 64'(req_at), 64'd1);
    check_vec("div_rf_we_cycle", 64'(rf_at), 64'd11);

    // five wait cycles: request and address held six cycles, instr latched on ack only
    do_reset();
    mem_delay = 5;
    prog[0] = 32'hC012_3456;
    start_run();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_vec($sformatf("wait_req%0d", i), {63'd0, imem_req}, 64'd1);
      check_vec($sformatf("wait_addr%0d", i), imem_addr, 64'h2000);
      check_vec($sformatf("wait_instr%0d", i), {32'd0, instr}, 64'd0);
    end
    step(1);
    check_vec("wait_req_drop", {63'd0, imem_req}, 64'd0);
    check_vec("wait_instr_latched", {32'd0, instr}, 64'hC012_3456);
    run = 1'b0;
    step(5);
    check_vec("wait_retired", {32'd0, retired}, 64'd1);
    check_vec("wait_idle_req", {63'd0, imem_req}, 64'd0);
    check_vec("wait_idle_halted", {63'd0, halted}, 64'd0);
    mem_delay = 0;

    // priv with nonzero literal is illegal
    do_reset();
    prog[0] = 32'h7800_0001;
    rf0 = rf_cnt;
    start_run();
    step(4);
    check_vec("privl_halted", {63'd0, halted}, 64'd1);
    check_vec("privl_illegal", {63'd0, illegal}, 64'd1);
    check_vec("privl_no_rf_we", 64'(rf_cnt - rf0), 64'd0);

    // unknown opcode 0x1F, then asynchronous reset out of HALT
    do_reset();
    prog[0] = 32'hF800_0000;
    start_run();
    step(4);
    check_vec("ill_halted", {63'd0, halted}, 64'd1);
    check_vec("ill_illegal", {63'd0, illegal}, 64'd1);
    rst_n = 1'b0;
    #1;
    check_vec("ill_rst_halted", {63'd0, halted}, 64'd0);
    check_vec("ill_rst_illegal", {63'd0, illegal}, 64'd0);
    check_vec("ill_rst_pc", pc, 64'h2000);

    // mulf with run dropped during EXEC, then reset during a later EXEC
    do_reset();
    prog[0] = 32'hB000_0000;
    prog[1] = 32'hB000_0000;
    rf0 = rf_cnt;
    start_run();
    step(4);
    run = 1'b0;
    step(8);
    check_vec("mulf_one_rf_we", 64'(rf_cnt - rf0), 64'd1);
    check_vec("mulf_retired", {32'd0, retired}, 64'd1);
    check_vec("mulf_pc", pc, 64'h2004);
    rq0 = req_cnt;
    step(5);
    check_vec("mulf_idle_no_req", 64'(req_cnt - rq0), 64'd0);
    run = 1'b1;
    step(3);
    check_vec("mulf2_in_exec_rf_we", {63'd0, rf_we}, 64'd0);
    rf0 = rf_cnt;
    rst_n = 1'b0;
    run = 1'b0;
    #1;
    check_vec("mulf2_rst_pc", pc, 64'h2000);
    step(10);
    rst_n = 1'b1;
    step(3);
    check_vec("mulf2_no_rf_we", 64'(rf_cnt - rf0), 64'd0);
    check_vec("mulf2_retired", {32'd0, retired}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/tinker_sequencer.md
# tinker_sequencer

Multi-cycle control FSM that drives the Tinker combinational datapath (decoder, register file, ALU/FPU). It fetches each 32-bit instruction from instruction memory over a req/ack handshake and holds it stable on the datapath's instruction input. It waits a per-opcode execute latency, then issues a single-cycle register-file write strobe and advances the PC. It is the only source of sequencing for the core: the datapath itself has no clock.

## Interface
Parameters:
- RESET_PC, 64'h2000, PC value loaded on reset.
- MUL_LAT, 3, EXEC cycles for mul (≥1).
- DIV_LAT, 8, EXEC cycles for div (≥1).
- FP_LAT, 4, EXEC cycles for addf/subf/mulf/divf (≥1).

Ports:
- clk  in  1  core clock; one clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  level enable; sequencer fetches while high.
- imem_req  out  1  fetch request, held until ack.
- imem_addr  out  64  fetch address (= pc), stable while imem_req.
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction.
- instr  out  32  latched instruction to datapath.
- rf_we  out  1  register-file write strobe, one cycle per retired instruction.
- pc  out  64  current PC.
- halted  out  1  in HALT state.
- illegal  out  1  sticky; halt was caused by an unknown opcode.
- retired  out  32  retired-instruction counter.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE: all strobes low. Go to FETCH when run=1.
- FETCH: imem_req=1 and imem_addr=pc. On imem_ack, latch imem_rdata into instr and go to DECODE. Ack is legal in the first req cycle. Ack seen outside FETCH is ignored.
- DECODE (1 cycle): classify opcode instr[31:27].
  - Single-cycle class: 0x00–0x07, 0x11, 0x12, 0x18–0x1B.
  - mul: 0x1C. div: 0x1D. FP class: 0x14–0x17.
  - Load the EXEC counter with lat−1, where lat is 1, MUL_LAT, DIV_LAT or FP_LAT by class; go to EXEC.
  - Opcode 0x0F with instr[11:0]=0: HALT, illegal=0.
  - Any other opcode: HALT, illegal=1.
- EXEC: counter decrements each cycle; at 0, go to WB.
- WB (1 cycle): rf_we=1, pc ← pc+4 (wraps mod 2^64), retired ← retired+1 (wraps mod 2^32). Next state is FETCH if run=1, else IDLE.
- run=0 mid-instruction: the current instruction completes through WB, then the FSM goes to IDLE. run is sampled only in IDLE and WB.
- HALT: absorbing. imem_req=0, rf_we=0, halted=1. Only rst_n exits.
- instr is held constant from DECODE through WB, so the datapath inputs stay stable during EXEC and the write.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, pc=RESET_PC, instr=0, rf_we=0, imem_req=0, halted=0, illegal=0, retired=0.
- Reset mid-operation aborts with no write strobe. A partially fetched instruction is discarded.
- Cycles per instruction = F + 1 + lat + 1, where F = cycles from imem_req rising to imem_ack inclusive (minimum 1).
  - Example: add with zero-wait memory takes 4 cycles.
  - Example: div with zero-wait memory takes 11 cycles with default parameters.
- Back-to-back instructions: WB is followed directly by FETCH of pc+4. There is no bubble beyond the state sequence.
- rf_we is registered (a state decode with no combinational path from inputs). It is high in exactly one cycle per instruction.
- imem_addr changes only while imem_req=0.

## Structure
- Shared package tinker_pkg holds:
  - opcode localparams (OP_ADD=5'h18 … OP_DIVF=5'h17, OP_PRIV=5'h0F);
  - the state enum seq_state_t {IDLE, FETCH, DECODE, EXEC, WB, HALT};
  - the latency-class enum op_class_t {CLS_1, CLS_MUL, CLS_DIV, CLS_FP, CLS_HALT, CLS_ILL}.
- Sub-module tinker_op_class: combinational opcode+literal → op_class_t. It is shared with the instruction decoder's legal-opcode list so the two cannot diverge.
- The counter width is $clog2 of the maximum latency parameter, plus 1.

## Test plan
- Reset, run=1, memory acks in 0 wait cycles with add (0xC0000000):
  - imem_addr=0x2000 in cycle 1;
  - rf_we is high exactly at cycle 4;
  - pc=0x2004 and retired=1 afterwards.
- div (opcode 0x1D) with DIV_LAT=8 → 8 EXEC cycles. rf_we occurs 11 cycles after the req rises.
- Memory ack delayed 5 cycles → imem_req and imem_addr are held stable for 6 cycles, and instr updates only on the ack cycle.
- Instruction 0x78000000 (priv, L=0) → halted=1, illegal=0, no rf_we, imem_req stays low across 20 cycles even with run=1.
- Opcode 0x1F → halted=1, illegal=1. Then assert rst_n=0 mid-HALT → immediate IDLE, pc=0x2000, illegal=0.
- Drop run during the EXEC of a mulf → that instruction retires (rf_we once), then IDLE with no further imem_req. Also assert rst_n=0 during a later EXEC → rf_we never asserts for that instruction.
